// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM pipeline stage: word data memory plus MEM/WB register.
// Optional misaligned-access trap enabled by defining MEMORY_STAGE_MISALIGN_CHECK_EN.
module memory_stage #(
    parameter int DEPTH = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALUOutM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [31:0] ResultW,
    output logic        MisalignW
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] ADDR_SPAN = 32'(4 * DEPTH);

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          misalign_access;
    logic          store_en;
    logic [31:0]   rd_data;

    logic          regwrite_q,  regwrite_d;
    logic          memtoreg_q,  memtoreg_d;
    logic [4:0]    writereg_q,  writereg_d;
    logic [31:0]   readdata_q,  readdata_d;
    logic [31:0]   aluout_q,    aluout_d;
    logic          misalign_q,  misalign_d;

    assign word_idx = ALUOutM[AW+1:2];
    assign in_range = (ALUOutM < ADDR_SPAN);

`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
    assign misalign_access = (MemWriteM || MemtoRegM) && (ALUOutM[1:0] != 2'b00);
`else
    assign misalign_access = 1'b0;
`endif

    assign store_en = MemWriteM && in_range && !misalign_access;

    // Read sees the pre-edge word, so a same-cycle load+store captures the old data.
    assign rd_data = in_range ? mem_q[word_idx] : 32'h0;

    always_comb begin
        regwrite_d = RegWriteM && !misalign_access;
        memtoreg_d = MemtoRegM;
        writereg_d = WriteRegM;
        readdata_d = rd_data;
        aluout_d   = ALUOutM;
        misalign_d = misalign_q || misalign_access;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (store_en) begin
            mem_q[word_idx] <= WriteDataM;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            writereg_q <= 5'd0;
            readdata_q <= 32'h0;
            aluout_q   <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            writereg_q <= writereg_d;
            readdata_q <= readdata_d;
            aluout_q   <= aluout_d;
            misalign_q <= misalign_d;
        end
    end

    assign RegWriteW = regwrite_q;
    assign MemtoRegW = memtoreg_q;
    assign WriteRegW = writereg_q;
    assign ReadDataW = readdata_q;
    assign ALUOutW   = aluout_q;
    assign MisalignW = misalign_q;
    assign ResultW   = memtoreg_q ? readdata_q : aluout_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage against a word-array model.
module tb_memory_stage;

    localparam int DEPTH = 64;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        RegWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [4:0]  WriteRegM = 5'd0;
    logic [31:0] WriteDataM = 32'h0;
    logic [31:0] ALUOutM = 32'h0;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [4:0]  WriteRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [31:0] ResultW;
    logic        MisalignW;

    memory_stage #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .WriteRegM  (WriteRegM),
        .WriteDataM (WriteDataM),
        .ALUOutM    (ALUOutM),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .WriteRegW  (WriteRegW),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW),
        .ResultW    (ResultW),
        .MisalignW  (MisalignW)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference state: plain word array and expected W-stage values.
    logic [31:0] ref_mem [DEPTH];
    logic        exp_regwrite, exp_memtoreg, exp_misalign;
    logic [4:0]  exp_writereg;
    logic [31:0] exp_readdata, exp_aluout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        exp_regwrite = 0; exp_memtoreg = 0; exp_misalign = 0;
        exp_writereg = 0; exp_readdata = 0; exp_aluout = 0;
    endtask

    // One rising edge of the reference: read old word, then maybe write.
    task automatic model_edge();
        bit inr, mis;
        int w;
        inr = (ALUOutM < 32'(4 * DEPTH));
        w   = int'(ALUOutM / 4) % DEPTH;
`ifdef MEMORY_STAGE_MISALIGN_CHECK_EN
        mis = (MemWriteM || MemtoRegM) && (ALUOutM % 4 != 0);
`else
        mis = 0;
`endif
        exp_readdata = inr ? ref_mem[w] : 32'h0;
        exp_regwrite = RegWriteM && !mis;
        exp_memtoreg = MemtoRegM;
        exp_writereg = WriteRegM;
        exp_aluout   = ALUOutM;
        exp_misalign = exp_misalign || mis;
        if (MemWriteM && inr && !mis) ref_mem[w] = WriteDataM;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(exp_regwrite));
        check({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'(exp_memtoreg));
        check({tag, ".WriteRegW"}, 32'(WriteRegW), 32'(exp_writereg));
        check({tag, ".ReadDataW"}, ReadDataW, exp_readdata);
        check({tag, ".ALUOutW"},   ALUOutW, exp_aluout);
        check({tag, ".ResultW"},   ResultW, exp_memtoreg ? exp_readdata : exp_aluout);
        check({tag, ".MisalignW"}, 32'(MisalignW), 32'(exp_misalign));
    endtask

    task automatic step(input string tag, input bit rw, input bit ld, input bit st,
                        input logic [4:0] rd, input logic [31:0] wd, input logic [31:0] addr);
        RegWriteM = rw; MemtoRegM = ld; MemWriteM = st;
        WriteRegM = rd; WriteDataM = wd; ALUOutM = addr;
        model_edge();
        @(posedge CLK);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs("reset");
        Reset = 1'b1;
        @(posedge CLK); #1;
        check_outputs("post_reset_idle");

        step("st_deadbeef", 0, 0, 1, 5'd0, 32'hDEADBEEF, 32'h10);
        step("ld_deadbeef", 1, 1, 0, 5'd5, 32'h0, 32'h10);
        check("ld_deadbeef.abs", ResultW, 32'hDEADBEEF);
        check("ld_deadbeef.rd", 32'(WriteRegW), 32'd5);

        step("alu_op", 1, 0, 0, 5'd7, 32'h0, 32'h1234);
        check("alu_op.abs", ResultW, 32'h1234);
        step("ld_after_alu", 1, 1, 0, 5'd1, 32'h0, 32'h10);

        step("st_oor", 0, 0, 1, 5'd0, 32'hA5A5A5A5, 32'h100);
        step("ld_oor", 1, 1, 0, 5'd2, 32'h0, 32'h100);
        check("ld_oor.abs", ReadDataW, 32'h0);
        step("ld_zero", 1, 1, 0, 5'd2, 32'h0, 32'h0);
        check("ld_zero.abs", ReadDataW, 32'h0);
        step("ld_last", 1, 1, 0, 5'd2, 32'h0, 32'(4 * DEPTH - 4));

        step("st_old", 0, 0, 1, 5'd0, 32'h1, 32'h8);
        step("ldst_same", 1, 1, 1, 5'd3, 32'h2, 32'h8);
        check("ldst_same.abs", ReadDataW, 32'h1);
        step("ld_new", 1, 1, 0, 5'd3, 32'h0, 32'h8);
        check("ld_new.abs", ReadDataW, 32'h2);

        // Misaligned accesses: behaviour depends on build, the model follows it.
        step("st_w1", 0, 0, 1, 5'd0, 32'h11111111, 32'h4);
        step("ld_mis", 1, 1, 0, 5'd9, 32'h0, 32'h6);
        step("st_mis", 0, 0, 1, 5'd0, 32'h22222222, 32'h5);
        step("ld_w1", 1, 1, 0, 5'd9, 32'h0, 32'h4);
        step("mis_sticky", 1, 0, 0, 5'd4, 32'h0, 32'h40);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 9);
            a = 32'($urandom_range(0, DEPTH + 7)) * 4;
            if (kind == 0) a = a + 32'($urandom_range(1, 3));
            if (kind == 1) a = $urandom;
            step("rand", 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 5'($urandom), $urandom, a);
        end

        // Asynchronous reset between edges, holding a store across an edge in reset.
        RegWriteM = 1; MemtoRegM = 0; MemWriteM = 1; WriteRegM = 5'd6;
        WriteDataM = 32'hCAFEF00D; ALUOutM = 32'h10;
        #3;
        Reset = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(posedge CLK); #1;
        check_outputs("reset_held");
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        check("release.ResultW", ResultW, 32'h0);
        check("release.RegWriteW", 32'(RegWriteW), 32'h0);
        step("ld_after_reset", 1, 1, 0, 5'd5, 32'h0, 32'h10);
        check("ld_after_reset.abs", ReadDataW, 32'h0);
        step("ld8_after_reset", 1, 1, 0, 5'd5, 32'h0, 32'h8);

        for (int n = 0; n < 100; n++) begin
            step("rand2", 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom), $urandom, 32'($urandom_range(0, DEPTH + 3)) * 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
